// File: rtl/dut_fifo_top_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dut_fifo_top_if : write/read handshake and status bundle for dut_fifo_top
// Rev 1.0
// ---------------------------------------------------------------------------
interface dut_fifo_top_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/dut_fifo_top.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dut_fifo_top : single-clock FIFO with registered read data and sticky errors
// Rev 1.0
// ---------------------------------------------------------------------------
module dut_fifo_top #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  wire logic       clk,
  input  wire logic       reset,
  dut_fifo_top_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_COUNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_COUNT   = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  overflow;
  logic                  underflow;

  logic full;
  logic empty;
  logic wr_accept;
  logic rd_accept;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  // Acceptance uses the pre-edge flags: a full FIFO still serves a read but
  // refuses the write, and an empty FIFO never forwards a same-cycle write.
  assign wr_accept = bus.wr_en && !full;
  assign rd_accept = bus.rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        rd_data  <= mem[rd_ptr];
        rd_valid <= 1'b1;
        rd_ptr   <= rd_ptr + 1'b1;
      end else begin
        rd_valid <= 1'b0;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.wr_en && full) begin
        overflow <= 1'b1;
      end
      if (bus.rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  assign bus.rd_data      = rd_data;
  assign bus.rd_valid     = rd_valid;
  assign bus.count        = count;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= AF_COUNT);
  assign bus.almost_empty = (count <= AE_COUNT);
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule
`default_nettype wire

// File: tb/tb_dut_fifo_top.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dut_fifo_top : directed + random traffic against a queue-based FIFO model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dut_fifo_top;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  dut_fifo_top_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  dut_fifo_top #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .AF_LEVEL  (DEPTH - 2),
    .AE_LEVEL  (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, flags derived from its size.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_rd  = '0;
  bit            m_rv  = 1'b0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;

  task automatic model_clear();
    mq.delete();
    m_rd  = '0;
    m_rv  = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  always @(negedge reset) model_clear();

  always @(posedge clk) begin
    if (!reset) begin
      model_clear();
    end else begin
      bit was_full, was_empty;
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (bus.wr_en && was_full)  m_ovf = 1'b1;
      if (bus.rd_en && was_empty) m_unf = 1'b1;
      if (bus.rd_en && !was_empty) begin
        m_rd = mq.pop_front();
        m_rv = 1'b1;
      end else begin
        m_rv = 1'b0;
      end
      if (bus.wr_en && !was_full) mq.push_back(bus.wr_data);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      n = mq.size();
      chk("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
      chk("rd_data", 32'(bus.rd_data), 32'(m_rd));
      chk("count", 32'(bus.count), 32'(n));
      chk("full", 32'(bus.full), 32'(n == DEPTH));
      chk("empty", 32'(bus.empty), 32'(n == 0));
      chk("almost_full", 32'(bus.almost_full), 32'(n >= DEPTH - 2));
      chk("almost_empty", 32'(bus.almost_empty), 32'(n <= 2));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("underflow", 32'(bus.underflow), 32'(m_unf));
    end
  end

  // One clock of stimulus; returns 1ns after the edge that consumed it.
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
    @(negedge clk);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    #2 reset = 1'b0;
    #1 chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Reset then idle
    cyc(0, 8'h00, 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_ae", 32'(bus.almost_empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_rv", 32'(bus.rd_valid), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_unf", 32'(bus.underflow), 0);

    // Three writes then three reads
    cyc(1, 8'h11, 0);
    cyc(1, 8'h22, 0);
    cyc(1, 8'h33, 0);
    chk("three_count", 32'(bus.count), 3);
    begin
      logic [DW-1:0] exp3 [3] = '{8'h11, 8'h22, 8'h33};
      for (int i = 0; i < 3; i++) begin
        cyc(0, 8'h00, 1);
        chk("three_rd_data", 32'(bus.rd_data), 32'(exp3[i]));
        chk("three_rd_valid", 32'(bus.rd_valid), 1);
        chk("three_count_dn", 32'(bus.count), 32'(2 - i));
      end
    end
    cyc(0, 8'h00, 0);
    chk("three_empty", 32'(bus.empty), 1);
    chk("three_rv_low", 32'(bus.rd_valid), 0);

    // Fill to full, almost_full threshold, dropped 17th write, drain
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 8'(i), 0);
      if (i == 12) chk("af_at_13", 32'(bus.almost_full), 0);
      if (i == 13) chk("af_at_14", 32'(bus.almost_full), 1);
    end
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_count", 32'(bus.count), 16);
    cyc(1, 8'hAA, 0);
    chk("ovf_set", 32'(bus.overflow), 1);
    chk("ovf_count", 32'(bus.count), 16);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 8'h00, 1);
      chk("drain_data", 32'(bus.rd_data), 32'(i));
    end
    cyc(0, 8'h00, 0);
    chk("drain_empty", 32'(bus.empty), 1);

    // Read while empty, sticky through later traffic
    cyc(0, 8'h00, 1);
    chk("unf_set", 32'(bus.underflow), 1);
    chk("unf_rv", 32'(bus.rd_valid), 0);
    chk("unf_count", 32'(bus.count), 0);
    cyc(1, 8'h5A, 0);
    cyc(0, 8'h00, 1);
    chk("unf_sticky", 32'(bus.underflow), 1);
    chk("unf_rd", 32'(bus.rd_data), 32'h5A);

    // Simultaneous write+read on empty: write only
    cyc(1, 8'h77, 1);
    chk("wr_rd_empty_rv", 32'(bus.rd_valid), 0);
    chk("wr_rd_empty_cnt", 32'(bus.count), 1);
    cyc(0, 8'h00, 1);
    chk("wr_rd_empty_data", 32'(bus.rd_data), 32'h77);

    // Hold count at 5 across 20 concurrent write+read cycles
    for (int i = 0; i < 5; i++) cyc(1, 8'(i), 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 8'(i + 5), 1);
      chk("steady_count", 32'(bus.count), 5);
      chk("steady_data", 32'(bus.rd_data), 32'(i));
    end

    // Async reset mid-burst at count 7
    for (int i = 0; i < 2; i++) cyc(1, 8'(i + 100), 0);
    chk("burst_count", 32'(bus.count), 7);
    #2;
    reset       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    #1;
    chk("async_count", 32'(bus.count), 0);
    chk("async_empty", 32'(bus.empty), 1);
    chk("async_ovf", 32'(bus.overflow), 0);
    @(negedge clk);
    reset = 1'b1;
    cyc(0, 8'h00, 1);
    chk("post_rst_unf", 32'(bus.underflow), 1);
    chk("post_rst_rv", 32'(bus.rd_valid), 0);

    // Randomised traffic with shifting write/read bias
    for (int i = 0; i < 1500; i++) begin
      int wp;
      wp = (((i / 250) % 3) == 0) ? 75 : ((((i / 250) % 3) == 1) ? 50 : 25);
      cyc(logic'($urandom_range(99) < wp), 8'($urandom),
          logic'($urandom_range(99) < (100 - wp)));
    end

    cyc(0, 8'h00, 0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
